// File: rtl/llpm_mem_pkg.sv
// Shared definitions for the LLPM block RAM family.
// Request layout helpers (field offsets, slice width) and the clear FSM state type.
// Optional clear-on-reset is enabled by the LLPM_BRAM_CLEAR_EN macro in block_ram_np.
package llpm_mem_pkg;

  // Request field offsets inside one port slice: {addr, data, wr}
  localparam int WR_BIT   = 0;
  localparam int DATA_LSB = 1;

  // Width of one port's request slice
  function automatic int req_width(input int width, input int addr_width);
    return width + addr_width + 1;
  endfunction

  // Address field starts right above the data field
  function automatic int addr_lsb(input int width);
    return width + 1;
  endfunction

  // Clear-on-reset sequencer states
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

endpackage

// File: rtl/block_ram_resp_stage.sv
// Per-port response register with valid/bp handshake and request backpressure.
// Latency: a request accepted at edge N is visible on resp from edge N onward.
// Backpressure: req_bp is high until init_done, or while a pending response is stalled.
module block_ram_resp_stage #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_init_done,
  input  logic             i_req_vld,
  input  logic             i_resp_bp,
  input  logic [Width-1:0] i_load_dat,
  output logic             o_req_bp,
  output logic             o_req_acc,
  output logic [Width-1:0] o_resp_dat,
  output logic             o_resp_vld
);

  logic             r_resp_vld;
  logic [Width-1:0] r_resp_dat;
  logic             w_resp_take;

  // A stalled response blocks new requests; a free or draining slot can be reloaded
  assign o_req_bp    = !i_init_done || (r_resp_vld && i_resp_bp);
  assign o_req_acc   = i_req_vld && !o_req_bp;
  assign w_resp_take = r_resp_vld && !i_resp_bp;

  // Response register: load on accept, drop valid once taken, clear on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_vld <= 1'b0;
      r_resp_dat <= '0;
    end else if (o_req_acc) begin
      r_resp_vld <= 1'b1;
      r_resp_dat <= i_load_dat;
    end else if (w_resp_take) begin
      r_resp_vld <= 1'b0;
    end
  end

  assign o_resp_vld = r_resp_vld;
  assign o_resp_dat = r_resp_dat;

endmodule

// File: rtl/block_ram_np.sv
// N-port read/write block RAM, read-first, lowest port index wins same-address writes.
// Latency: one cycle (response register loads at the accept edge); one request per cycle per port.
// Backpressure: per port, req_bp = !init_done || (resp_valid && resp_bp); optional clear via LLPM_BRAM_CLEAR_EN.
module block_ram_np
  import llpm_mem_pkg::*;
#(
  parameter string Name      = "",
  parameter int    Width     = 8,
  parameter int    Depth     = 8,
  parameter int    AddrWidth = 8,
  parameter int    NumPorts  = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NumPorts*req_width(Width,AddrWidth)-1:0] port_req,
  input  logic [NumPorts-1:0]                           port_req_valid,
  output logic [NumPorts-1:0]                           port_req_bp,
  output logic [NumPorts*Width-1:0]                     port_resp,
  output logic [NumPorts-1:0]                           port_resp_valid,
  input  logic [NumPorts-1:0]                           port_resp_bp,
  output logic                                          init_done
);

  localparam int ReqW    = req_width(Width, AddrWidth);
  localparam int AddrLsb = addr_lsb(Width);
  localparam int IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrWidth:0] DepthW = (AddrWidth + 1)'(Depth);

  // Elaboration-time parameter sanity
  if (Width < 1)                       $error("block_ram_np: Width must be >= 1");
  if (Depth < 2)                       $error("block_ram_np: Depth must be >= 2");
  if (NumPorts < 1 || NumPorts > 8)    $error("block_ram_np: NumPorts must be 1..8");
  if (AddrWidth < IdxW)                $error("block_ram_np: AddrWidth too small for Depth");

  // Storage is deliberately not reset
  logic [Width-1:0] r_mem [Depth];

  logic                 w_wr      [NumPorts];
  logic [AddrWidth-1:0] w_addr    [NumPorts];
  logic [Width-1:0]     w_wdat    [NumPorts];
  logic                 w_inrange [NumPorts];
  logic [IdxW-1:0]      w_idx     [NumPorts];
  logic [Width-1:0]     w_rdat    [NumPorts];
  logic [NumPorts-1:0]  w_acc;
  logic                 w_init_done;

  // Per-port request decode, old-word read and response stage
  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic [ReqW-1:0] w_slice;
    assign w_slice      = port_req[p*ReqW +: ReqW];
    assign w_wr[p]      = w_slice[WR_BIT];
    assign w_wdat[p]    = w_slice[DATA_LSB +: Width];
    assign w_addr[p]    = w_slice[AddrLsb +: AddrWidth];
    assign w_inrange[p] = ({1'b0, w_addr[p]} < DepthW);
    assign w_idx[p]     = w_addr[p][IdxW-1:0];
    // Sampled before this edge's writes land, so every response is read-first
    assign w_rdat[p]    = w_inrange[p] ? r_mem[w_idx[p]] : '0;

    block_ram_resp_stage #(
      .Width (Width)
    ) u_resp (
      .clk         (clk),
      .reset       (reset),
      .i_init_done (w_init_done),
      .i_req_vld   (port_req_valid[p]),
      .i_resp_bp   (port_resp_bp[p]),
      .i_load_dat  (w_rdat[p]),
      .o_req_bp    (port_req_bp[p]),
      .o_req_acc   (w_acc[p]),
      .o_resp_dat  (port_resp[p*Width +: Width]),
      .o_resp_vld  (port_resp_valid[p])
    );
  end

`ifdef LLPM_BRAM_CLEAR_EN
  clr_state_t      r_state;
  clr_state_t      w_state_nxt;
  logic [IdxW-1:0] r_clr_addr;
  logic [IdxW-1:0] w_clr_addr_nxt;
  logic            w_clr_we;

  // Clear sequencer state and address counter; reset restarts the sweep at word 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Clear sequencer next state: one zero write per cycle, READY after the last word
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clr_we       = 1'b0;
    w_init_done    = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clr_we = !reset;
        if (r_clr_addr == IdxW'(Depth - 1)) begin
          w_state_nxt = READY;
        end else begin
          w_clr_addr_nxt = r_clr_addr + 1'b1;
        end
      end
      READY: begin
        w_init_done = 1'b1;
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Memory update: clear sweep, then port writes; lower ports are applied later so they win
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_addr] <= '0;
    end
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if (w_acc[p] && w_wr[p] && w_inrange[p]) begin
        r_mem[w_idx[p]] <= w_wdat[p];
      end
    end
  end
`else
  logic r_init_done;

  // Ready on the first edge after reset releases; contents stay whatever they were
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
    end
  end

  assign w_init_done = r_init_done;

  // Memory update: port writes; lower ports are applied later so they win
  always_ff @(posedge clk) begin
    for (int p = NumPorts - 1; p >= 0; p--) begin
      if (w_acc[p] && w_wr[p] && w_inrange[p]) begin
        r_mem[w_idx[p]] <= w_wdat[p];
      end
    end
  end
`endif

  assign init_done = w_init_done;

endmodule

// File: tb/tb_block_ram_np.sv
// Directed bench for block_ram_np (2 ports, 8-bit words, Depth 6 so addresses 6/7 are out of range).
// Inputs change on the falling edge; outputs are checked on the falling edge (plus #1 for combinational bp).
// Build with LLPM_BRAM_CLEAR_EN to also exercise the clear-on-reset sweep.
module tb_block_ram_np;

  localparam int W   = 8;
  localparam int D   = 6;
  localparam int AW  = 8;
  localparam int NP  = 2;
  localparam int RW  = W + AW + 1;
`ifdef LLPM_BRAM_CLEAR_EN
  localparam int INIT_CYC = D;
  localparam bit CLR      = 1'b1;
`else
  localparam int INIT_CYC = 1;
  localparam bit CLR      = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [NP*RW-1:0]  port_req;
  logic [NP-1:0]     port_req_valid;
  logic [NP-1:0]     port_req_bp;
  logic [NP*W-1:0]   port_resp;
  logic [NP-1:0]     port_resp_valid;
  logic [NP-1:0]     port_resp_bp;
  logic              init_done;

  int n_checks = 0;
  int n_err    = 0;

  block_ram_np #(
    .Name      ("tb_ram"),
    .Width     (W),
    .Depth     (D),
    .AddrWidth (AW),
    .NumPorts  (NP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .port_req        (port_req),
    .port_req_valid  (port_req_valid),
    .port_req_bp     (port_req_bp),
    .port_resp       (port_resp),
    .port_resp_valid (port_resp_valid),
    .port_resp_bp    (port_resp_bp),
    .init_done       (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input bit v, input bit wr, input logic [7:0] a, input logic [7:0] d);
    port_req[p*RW +: RW] = {a, d, wr};
    port_req_valid[p]    = v;
  endtask

  task automatic idle();
    port_req_valid = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [7:0] resp(input int p);
    return port_resp[p*W +: W];
  endfunction

  // Counts edges after reset release until init_done; also watches req_bp stays high meanwhile
  task automatic wait_init(output int cyc, output bit bp_ok);
    cyc   = -1;
    bp_ok = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk);
      #1;
      if (init_done !== 1'b1 && port_req_bp !== 2'b11) bp_ok = 1'b0;
      if (init_done === 1'b1) begin
        cyc = i;
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int          cyc;
    bit          bp_ok;
    logic [7:0]  exp_mem [6];

    reset          = 1'b1;
    port_req       = '0;
    port_req_valid = '0;
    port_resp_bp   = '0;
    exp_mem        = '{8'h30, 8'h31, 8'h99, 8'hA5, 8'h34, 8'h11};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_resp_valid", 32'(port_resp_valid), 32'h0);
    check("rst_resp",       32'(port_resp),       32'h0);
    check("rst_init_done",  32'(init_done),       32'h0);
    check("rst_req_bp",     32'(port_req_bp),     32'h3);
    @(negedge clk);
    reset = 1'b0;
    wait_init(cyc, bp_ok);
    check("init_cycles", 32'(cyc), 32'(INIT_CYC));
    check("init_bp_held", 32'(bp_ok), 32'h1);
    check("ready_req_bp", 32'(port_req_bp), 32'h0);

`ifdef LLPM_BRAM_CLEAR_EN
    // Every word reads back zero after the clear sweep
    for (int a = 0; a < D; a++) begin
      drive(0, 1, 0, 8'(a), 8'h00);
      step();
      check("clear_word", 32'(resp(0)), 32'h0);
    end
    idle();
    step();
`endif

    // Write then cross-port read, one-cycle latency
    drive(0, 1, 1, 8'd3, 8'hA5);
    step();
    check("wr_resp_valid", 32'(port_resp_valid[0]), 32'h1);
    idle();
    drive(1, 1, 0, 8'd3, 8'h00);
    #1;
    check("rd_valid_before", 32'(port_resp_valid[1]), 32'h0);
    step();
    check("rd_valid_after", 32'(port_resp_valid[1]), 32'h1);
    check("rd_data",        32'(resp(1)),            32'hA5);
    check("wr_resp_taken",  32'(port_resp_valid[0]), 32'h0);
    idle();
    step();

    // Same-address collision: port 0 wins, both see the old word
    drive(0, 1, 1, 8'd5, 8'h40);
    step();
    drive(0, 1, 1, 8'd5, 8'h11);
    drive(1, 1, 1, 8'd5, 8'h22);
    step();
    check("coll_valid", 32'(port_resp_valid), 32'h3);
    check("coll_old0",  32'(resp(0)), 32'h40);
    check("coll_old1",  32'(resp(1)), 32'h40);
    idle();
    drive(1, 1, 0, 8'd5, 8'h00);
    step();
    check("coll_winner", 32'(resp(1)), 32'h11);
    idle();

    // Read-first: same-cycle write and cross-port read
    drive(0, 1, 1, 8'd2, 8'h07);
    step();
    drive(0, 1, 1, 8'd2, 8'h99);
    drive(1, 1, 0, 8'd2, 8'h00);
    step();
    check("rf_cross_read", 32'(resp(1)), 32'h07);
    check("rf_write_old",  32'(resp(0)), 32'h07);
    idle();
    drive(1, 1, 0, 8'd2, 8'h00);
    step();
    check("rf_next_read", 32'(resp(1)), 32'h99);
    idle();
    step();

    // Backpressure on port 0 for three cycles, port 1 keeps streaming
    port_resp_bp = 2'b01;
    drive(0, 1, 0, 8'd3, 8'h00);
    drive(1, 1, 0, 8'd5, 8'h00);
    step();
    drive(0, 1, 0, 8'd2, 8'h00);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_req_bp0",  32'(port_req_bp[0]),     32'h1);
      check("bp_hold_dat", 32'(resp(0)),            32'hA5);
      check("bp_hold_vld", 32'(port_resp_valid[0]), 32'h1);
      check("bp_req_bp1",  32'(port_req_bp[1]),     32'h0);
      check("bp_p1_data",  32'(resp(1)),            32'h11);
      step();
    end
    port_resp_bp = 2'b00;
    #1;
    check("bp_release", 32'(port_req_bp[0]), 32'h0);
    step();
    check("bp_next_vld", 32'(port_resp_valid[0]), 32'h1);
    check("bp_next_dat", 32'(resp(0)),            32'h99);
    idle();
    step();

    // Out-of-range writes are ignored and read back as zero
    drive(0, 1, 1, 8'd0, 8'h30);
    step();
    drive(0, 1, 1, 8'd1, 8'h31);
    step();
    drive(0, 1, 1, 8'd4, 8'h34);
    step();
    drive(0, 1, 1, 8'd7, 8'hFF);
    step();
    check("oor_wr7_resp", 32'(resp(0)), 32'h0);
    drive(0, 1, 1, 8'd6, 8'hFF);
    step();
    check("oor_wr6_resp", 32'(resp(0)), 32'h0);
    check("oor_wr6_vld",  32'(port_resp_valid[0]), 32'h1);
    for (int a = 0; a < D; a++) begin
      drive(0, 1, 0, 8'(a), 8'h00);
      step();
      check("oor_word_kept", 32'(resp(0)), 32'(exp_mem[a]));
    end
    drive(0, 1, 0, 8'd7, 8'h00);
    step();
    check("oor_rd7", 32'(resp(0)), 32'h0);
    drive(0, 1, 0, 8'd6, 8'h00);
    step();
    check("oor_rd6", 32'(resp(0)), 32'h0);
    idle();
    step();

    // Reset mid-operation drops pending responses, committed writes survive (unless cleared)
    port_resp_bp = 2'b01;
    drive(0, 1, 0, 8'd3, 8'h00);
    step();
    check("mid_pending", 32'(port_resp_valid[0]), 32'h1);
    idle();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_vld",  32'(port_resp_valid), 32'h0);
    check("mid_rst_resp", 32'(port_resp),       32'h0);
    check("mid_rst_init", 32'(init_done),       32'h0);
    @(negedge clk);
    reset        = 1'b0;
    port_resp_bp = 2'b00;
    wait_init(cyc, bp_ok);
    check("mid_init_cycles", 32'(cyc), 32'(INIT_CYC));
    drive(1, 1, 0, 8'd3, 8'h00);
    step();
    check("mid_persist", 32'(resp(1)), CLR ? 32'h0 : 32'hA5);
    idle();
    step();

`ifdef LLPM_BRAM_CLEAR_EN
    // Reset pulse four cycles into the sweep restarts the full count
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pulse_not_ready", 32'(init_done),   32'h0);
    check("pulse_bp",        32'(port_req_bp), 32'h3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_init(cyc, bp_ok);
    check("pulse_restart_cycles", 32'(cyc),   32'(D));
    check("pulse_bp_held",        32'(bp_ok), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
